// File: rtl/float_to_linear_decoder.sv
// Expands a compact float sample {S, E, F} to a two's-complement linear value, one shift per clock.
// Optional build macro ROUND_MID_EN: reconstruct the quantisation-interval midpoint before negation.
module float_to_linear_decoder #(
    parameter int EXP_W  = 3,
    parameter int MANT_W = 4,
    parameter int OUT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              S,
    input  logic [EXP_W-1:0]  E,
    input  logic [MANT_W-1:0] F,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  D
);

    localparam int MAG_W  = OUT_W - 1;
    localparam int SEXP_W = EXP_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic                     sign_q;
    logic [MAG_W-1:0]         mag_q;
    logic [EXP_W-1:0]         cnt_q;
    logic signed [OUT_W-1:0]  d_q;
    logic                     out_valid_q;
    logic [MAG_W-1:0]         mag_final;

    // Midpoint of the interval covered by the shifted-out bits; zero magnitude stays exactly zero.
    function automatic logic [MAG_W-1:0] add_midpoint(input logic [MAG_W-1:0] m,
                                                      input logic [SEXP_W-1:0] e);
        logic [MAG_W-1:0] mid;
        mid = '0;
        if (e != '0 && m != '0)
            mid = MAG_W'(1) << (e - SEXP_W'(1));
        return m | mid;
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic s,
                                                           input logic [MAG_W-1:0] m);
        logic signed [OUT_W-1:0] ext;
        ext = signed'({1'b0, m});
        return s ? -ext : ext;
    endfunction

`ifdef ROUND_MID_EN
    logic [SEXP_W-1:0] exp_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            exp_q <= '0;
        else if (state == IDLE && in_valid)
            exp_q <= SEXP_W'(E);
    end

    assign mag_final = add_midpoint(mag_q, exp_q);
`else
    assign mag_final = mag_q;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_q;
    assign D         = d_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (in_valid) state_next = (E != '0) ? SHIFT : NEGATE;
            SHIFT:  if (cnt_q == EXP_W'(1)) state_next = NEGATE;
            NEGATE: state_next = DONE;
            DONE:   if (out_valid_q && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture in IDLE, shift per clock, sign-apply once, then hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q      <= 1'b0;
            mag_q       <= '0;
            cnt_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= S;
                        mag_q  <= MAG_W'(F);
                        cnt_q  <= E;
                    end
                end
                SHIFT: begin
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q - EXP_W'(1);
                end
                NEGATE: begin
                    d_q         <= apply_sign(sign_q, mag_final);
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_linear_decoder.sv
// Bench for float_to_linear_decoder: directed table, backpressure/abort sequences, random samples vs. model.
module tb_float_to_linear_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] D;

    int checks = 0;
    int failures = 0;

    float_to_linear_decoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready), .D(D)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] d;
    } vec_t;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic on the float fields.
    function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
        int mag;
        mag = int'(f) * (1 << e);
`ifdef ROUND_MID_EN
        if (e != 0 && f != 0)
            mag = mag + (1 << (int'(e) - 1));
`endif
        return s ? 12'(-mag) : 12'(mag);
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic capture(input logic s, input logic [2:0] e, input logic [3:0] f);
        @(negedge clk);
        in_valid = 1'b1; S = s; E = e; F = f;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_sample(input logic s, input logic [2:0] e, input logic [3:0] f,
                              input logic [11:0] req_d, input int hold, input string tag);
        int n;
        int stable;
        wait_ready();
        capture(s, e, f);
        chk({tag, "_in_ready_low"}, int'(in_ready), 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, int'(e) + 1);
        chk({tag, "_D"}, int'(D), int'(req_d));
        stable = 1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (D !== req_d || out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, stable, 1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_out_valid_fall"}, int'(out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        int seen;
        logic [11:0] d_hold;
        logic        rs;
        logic [2:0]  re;
        logic [3:0]  rf;

        vecs[0] = '{1'b0, 3'd0, 4'd0,  12'h000};
        vecs[1] = '{1'b1, 3'd5, 4'd0,  12'h000};
        vecs[2] = '{1'b1, 3'd0, 4'd1,  12'hFFF};
        vecs[3] = '{1'b0, 3'd0, 4'd9,  12'h009};
`ifdef ROUND_MID_EN
        vecs[4] = '{1'b0, 3'd7, 4'd15, 12'h7C0};
        vecs[5] = '{1'b1, 3'd3, 4'd9,  12'hFB4};
        vecs[6] = '{1'b0, 3'd1, 4'd1,  12'h003};
        vecs[7] = '{1'b1, 3'd7, 4'd15, 12'h840};
`else
        vecs[4] = '{1'b0, 3'd7, 4'd15, 12'h780};
        vecs[5] = '{1'b1, 3'd3, 4'd9,  12'hFB8};
        vecs[6] = '{1'b0, 3'd1, 4'd1,  12'h002};
        vecs[7] = '{1'b1, 3'd7, 4'd15, 12'h880};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S = 1'b0; E = '0; F = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_D", int'(D), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_sample(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].d, i % 3, $sformatf("vec%0d", i));

        // Backpressure: hold 5 cycles while offering a competing sample that must be ignored.
        wait_ready();
        capture(1'b1, 3'd3, 4'd9);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_D", int'(D), int'(model(1'b1, 3'd3, 4'd9)));
        @(negedge clk);
        in_valid = 1'b1; S = 1'b0; E = 3'd0; F = 4'd5;
        seen = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (D !== model(1'b1, 3'd3, 4'd9) || out_valid !== 1'b1 || in_ready !== 1'b0) seen = 0;
        end
        chk("bp_stable_5", seen, 1);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_out_valid_fall", int'(out_valid), 0);
        chk("bp_in_ready_back", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("bp_no_ghost_capture", seen, 0);
        chk("bp_D_kept", int'(D), int'(model(1'b1, 3'd3, 4'd9)));

        // Mid-cycle asynchronous reset while a result is pending.
        capture(1'b0, 3'd2, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_async_out_valid", int'(out_valid), 1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_D", int'(D), 0);
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Reset during SHIFT discards the sample.
        capture(1'b1, 3'd6, 4'd11);
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1;
        end
        chk("abort_no_output", seen, 0);
        run_sample(1'b1, 3'd4, 4'd13, model(1'b1, 3'd4, 4'd13), 1, "after_abort");

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            re = 3'($urandom);
            rf = 4'($urandom);
            run_sample(rs, re, rf, model(rs, re, rf), int'($urandom_range(0, 3)),
                       $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
